// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter. It sends DATA_BITS-wide words LSB first,
// framed as a start bit, an optional parity bit and STOP_BITS stop bits.
// A one-entry holding register behind a valid/ready handshake lets the next
// word wait while a frame is on the line, so frames go out back-to-back.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : a parity bit follows the data bits (even, or odd when
//               PARITY_ODD=1), computed from the word as loaded.
//   undefined : no parity bit and no parity logic; PARITY_ODD is ignored.
//
// Ports:
//   clk          system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_data       word to send, sampled when i_valid && o_ready
//   i_valid      producer has a word on i_data
//   o_ready      holding register empty (registered)
//   o_tx         serial line, registered, idles high
//   o_busy       frame in flight or holding register full (registered)
//   o_frame_done one-cycle pulse the cycle after the last stop bit ends
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for a held word
// START  | start bit (line low) for one bit period
// DATA   | data bits, shifter bit 0 on the line, shifted right per bit
// PARITY | parity bit for one bit period (UART_TX_PARITY_EN only)
// STOP   | line high for STOP_BITS bit periods, then reload or idle
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10416,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
      $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   ready_q, ready_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;
  logic                   xfer;
  logic                   load;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);
  assign xfer    = i_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    baud_d      = bit_end ? '0 : baud_q + 1'b1;
    idx_d       = idx_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
            stop_d  = 1'b0;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              // Next word is waiting: its start bit follows with no idle gap.
              load    = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end
    // xfer and load never coincide: xfer needs an empty hold, load a full one.
    if (xfer) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end

    ready_d = !hold_full_d;
    busy_d  = (state_d != S_IDLE) || hold_full_d;

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (load) begin
      par_d = (^hold_q) ^ (PARITY_ODD != 0);
    end
  end
`endif

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign o_ready      = ready_q;
  assign o_tx         = tx_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;
  localparam int CPB = 4;

`ifdef UART_TX_PARITY_EN
  localparam int NB8 = 11;
  localparam int NB7 = 11;
  localparam logic [15:0] F_A5 = 16'b0000_0101_0100_1010;
  localparam logic [15:0] F_00 = 16'b0000_0100_0000_0000;
  localparam logic [15:0] F_FF = 16'b0000_0101_1111_1110;
  localparam logic [15:0] F7_7F = 16'b0000_0111_1111_1110;
  localparam logic [15:0] F_03E = 16'b0000_0100_0000_0110;
  localparam logic [15:0] F_03O = 16'b0000_0110_0000_0110;
  localparam logic [15:0] F_07E = 16'b0000_0110_0000_1110;
  localparam logic [15:0] F7_55 = 16'b0000_0110_1010_1010;
  localparam logic [15:0] F_5A = 16'b0000_0100_1011_0100;
`else
  localparam int NB8 = 10;
  localparam int NB7 = 10;
  localparam logic [15:0] F_A5 = 16'b0000_0011_0100_1010;
  localparam logic [15:0] F_00 = 16'b0000_0010_0000_0000;
  localparam logic [15:0] F_FF = 16'b0000_0011_1111_1110;
  localparam logic [15:0] F7_7F = 16'b0000_0011_1111_1110;
  localparam logic [15:0] F_03E = 16'b0000_0010_0000_0110;
  localparam logic [15:0] F_03O = 16'b0000_0010_0000_0110;
  localparam logic [15:0] F_07E = 16'b0000_0010_0000_1110;
  localparam logic [15:0] F7_55 = 16'b0000_0011_1010_1010;
  localparam logic [15:0] F_5A = 16'b0000_0010_1011_0100;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] din [3];
  logic       vin [3];
  logic       tx  [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       dn  [3];

  int total = 0;
  int bad   = 0;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .i_reset_n(rst_n), .i_data(din[0]), .i_valid(vin[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(bsy[0]), .o_frame_done(dn[0]));

  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
    .clk(clk), .i_reset_n(rst_n), .i_data(din[1][6:0]), .i_valid(vin[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(bsy[1]), .o_frame_done(dn[1]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .i_reset_n(rst_n), .i_data(din[2]), .i_valid(vin[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(bsy[2]), .o_frame_done(dn[2]));

  typedef struct {
    int          sel;
    logic [7:0]  word;
    int          nb;
    logic [15:0] fr;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm, input int sel);
    chk($sformatf("%s tx", nm), tx[sel], 1);
    chk($sformatf("%s ready", nm), rdy[sel], 1);
    chk($sformatf("%s busy", nm), bsy[sel], 0);
    chk($sformatf("%s done", nm), dn[sel], 0);
  endtask

  task automatic run_frame(input int sel, input logic [7:0] word, input int nb,
                           input logic [15:0] fr, input string nm);
    @(negedge clk);
    chk($sformatf("%s ready before", nm), rdy[sel], 1);
    din[sel] = word;
    vin[sel] = 1'b1;
    @(posedge clk);
    #1;
    vin[sel] = 1'b0;
    din[sel] = ~word;
    @(negedge clk);
    chk($sformatf("%s tx at transfer", nm), tx[sel], 1);
    chk($sformatf("%s ready after xfer", nm), rdy[sel], 0);
    chk($sformatf("%s busy after xfer", nm), bsy[sel], 1);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk($sformatf("%s tx bit%0d cyc%0d", nm, b, c), tx[sel], fr[b]);
        chk($sformatf("%s done early b%0d", nm, b), dn[sel], 0);
        chk($sformatf("%s busy b%0d", nm, b), bsy[sel], 1);
        if (b == 0 && c == 0) chk($sformatf("%s ready after load", nm), rdy[sel], 1);
      end
    end
    @(negedge clk);
    chk($sformatf("%s done pulse", nm), dn[sel], 1);
    chk($sformatf("%s tx after frame", nm), tx[sel], 1);
    @(negedge clk);
    chk($sformatf("%s done cleared", nm), dn[sel], 0);
    chk($sformatf("%s busy cleared", nm), bsy[sel], 0);
    chk($sformatf("%s tx idle", nm), tx[sel], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    logic exp_tx;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      vin[i] = 1'b0;
    end

    vt[0] = '{0, 8'hA5, NB8, F_A5};
    vt[1] = '{0, 8'h00, NB8, F_00};
    vt[2] = '{0, 8'hFF, NB8, F_FF};
    vt[3] = '{1, 8'h7F, NB7, F7_7F};
    vt[4] = '{0, 8'h03, NB8, F_03E};
    vt[5] = '{2, 8'h03, NB8, F_03O};
    vt[6] = '{0, 8'h07, NB8, F_07E};
    vt[7] = '{1, 8'h55, NB7, F7_55};

    // reset held, then released: line stays idle
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_idle($sformatf("reset u%0d", i), i);
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_idle($sformatf("post reset u%0d", i), i);
    end

    for (int v = 0; v < 8; v++) begin
      run_frame(vt[v].sel, vt[v].word, vt[v].nb, vt[v].fr, $sformatf("vec%0d", v));
    end

    // back-to-back: 0x00 then 0xFF offered during frame 1
    L = NB8 * CPB;
    @(negedge clk);
    din[0] = 8'h00;
    vin[0] = 1'b1;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    for (int k = 0; k <= 2 * L + 2; k++) begin
      @(negedge clk);
      if (k == 0 || k > 2 * L) exp_tx = 1'b1;
      else if (k <= L) exp_tx = F_00[(k - 1) / CPB];
      else exp_tx = F_FF[(k - L - 1) / CPB];
      chk($sformatf("b2b tx k%0d", k), tx[0], exp_tx);
      chk($sformatf("b2b done k%0d", k), dn[0], (k == L + 1 || k == 2 * L + 1) ? 1 : 0);
      chk($sformatf("b2b ready k%0d", k), rdy[0], (k == 0 || (k >= 9 && k <= L)) ? 0 : 1);
      chk($sformatf("b2b busy k%0d", k), bsy[0], (k <= 2 * L) ? 1 : 0);
      if (k == 8) begin
        din[0] = 8'hFF;
        vin[0] = 1'b1;
      end
      if (k == 9) vin[0] = 1'b0;
    end

    // reset during data bit 3 with a second word held
    @(negedge clk);
    din[0] = 8'h00;
    vin[0] = 1'b1;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    din[0] = 8'hFF;
    vin[0] = 1'b1;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("midreset tx before", tx[0], 0);
    chk("midreset ready before", rdy[0], 0);
    chk("midreset busy before", bsy[0], 1);
    rst_n = 1'b0;
    #1;
    chk_idle("midreset async", 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk_idle("midreset after", 0);
    end
    run_frame(0, 8'h5A, NB8, F_5A, "after reset 5A");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. It serialises DATA_BITS-wide words onto a single line in LSB-first order, framed with a start bit, an optional parity bit and 1 or 2 stop bits. Words arrive through a valid/ready handshake into a one-entry holding register, so consecutive frames go out back-to-back with no idle gap. It sits between on-chip producers and the board-level TX pin, and is the generalised successor of the team's fixed 8N1 transmitter.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 10416, clk cycles per bit period; must be >= 2. Default gives 9600 baud at 100 MHz.
STOP_BITS, 1, number of stop bits; must be 1 or 2.
PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
clk  input  1  system clock; all flops on the rising edge.
i_reset_n  input  1  reset, asynchronous and active-low.
i_data  input  DATA_BITS  word to send; sampled only on handshake.
i_valid  input  1  producer has a word on i_data.
o_ready  output  1  holding register empty; a transfer occurs on any clk edge where i_valid && o_ready.
o_tx  output  1  serial line, registered; idles high.
o_busy  output  1  high while a frame is in flight or the holding register is full.
o_frame_done  output  1  one-cycle pulse, high the cycle after the last stop bit ends.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - o_tx=1, o_ready=1, o_busy=0, o_frame_done=0.
  - State IDLE; baud counter, bit index and holding register cleared.
  - Reset mid-frame aborts the frame immediately and drops any held word.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1. A bit ends when the count is CLKS_PER_BIT-1; the counter then wraps to 0.
- Every bit lasts exactly CLKS_PER_BIT cycles. Frame length is CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) cycles, where P=1 with parity, else 0.
- Handshake:
  - Transfer at edge E loads the holding register. o_ready goes low from E.
  - o_ready is a registered !hold_full; it is never a combinational function of i_valid.
  - i_valid while o_ready=0 is ignored; the producer must hold i_data and i_valid.
  - i_data changes outside a transfer have no effect.
- IDLE -> START: at the first edge where IDLE and hold_full.
  - The shifter loads from the holding register on that edge; hold clears and o_ready rises.
  - o_tx=0 from that edge.
  - Latency: a transfer at edge E into an idle block drives o_tx low at edge E+1.
- START -> DATA after 1 bit period. DATA sends shifter bit 0 first and shifts right; bit index runs 0..DATA_BITS-1.
- After the last data bit: DATA -> PARITY (macro defined) or DATA -> STOP.
- STOP: o_tx=1 for STOP_BITS bit periods. On the final cycle of the last stop bit:
  - hold_full: load the next word, go to START, pulse o_frame_done. There is no high cycle between stop and the next start bit.
  - else: go to IDLE and pulse o_frame_done.
- o_busy = (state != IDLE) || hold_full, registered.
- Elaboration error on an illegal DATA_BITS, STOP_BITS or CLKS_PER_BIT.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - The PARITY state is inserted after DATA for one bit period.
  - Parity bit = ^data when PARITY_ODD=0 (even), ~^data when PARITY_ODD=1 (odd). It is computed from the word as loaded into the shifter.
- Undefined:
  - No PARITY state, no parity logic, P=0.
  - PARITY_ODD is ignored.

Test Plan:
1. Reset: hold i_reset_n=0 mid-idle, then release -> o_tx=1, o_ready=1, o_busy=0, o_frame_done=0 throughout; no tx activity after release.
2. Single frame, DATA_BITS=8, CLKS_PER_BIT=4, word 0xA5 ->
   - o_tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
   - Start bit falls 1 cycle after the transfer.
   - o_frame_done pulses once, 40 cycles after the start bit begins; o_busy low the following cycle.
3. Back-to-back, CLKS_PER_BIT=4: send 0x00, then 0xFF during frame 1 ->
   - o_ready=0 from the second transfer until frame 2 loads.
   - Frame 2's start bit immediately follows frame 1's 4-cycle stop bit; no idle-high gap.
   - Two o_frame_done pulses 40 cycles apart.
4. DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, word 0x7F -> 7 data ones then line high for 8 stop cycles; frame is 40 cycles.
5. UART_TX_PARITY_EN defined, DATA_BITS=8:
   - 0x03 with PARITY_ODD=0 -> parity 0.
   - 0x03 with PARITY_ODD=1 -> parity 1.
   - 0x07 with PARITY_ODD=0 -> parity 1.
   - In every case the frame is 44 cycles at CLKS_PER_BIT=4.
6. Reset mid-frame: assert i_reset_n=0 during data bit 3 with a word held ->
   - o_tx=1 asynchronously, o_ready=1, o_busy=0, held word dropped.
   - After release, a new 0x5A frame transmits correctly.
